// File: rtl/generator_seq_ctrl_if.sv
// Handshake and parameter bus for the sequenced 2-3-9 generator network.
// master drives start, inputs, weights and biases; slave returns busy, done and y_out.
interface generator_seq_ctrl_if #(
    parameter int WIDTH       = 32,
    parameter int N_INPUT     = 2,
    parameter int N_NEURON_L2 = 3,
    parameter int N_NEURON_L3 = 9
);
    logic                                   start;
    logic [WIDTH-1:0]                       a_1;
    logic [WIDTH-1:0]                       a_2;
    logic [N_INPUT*N_NEURON_L2*WIDTH-1:0]   w_L2;
    logic [N_NEURON_L2*N_NEURON_L3*WIDTH-1:0] w_L3;
    logic [N_NEURON_L2*WIDTH-1:0]           b_L2;
    logic [N_NEURON_L3*WIDTH-1:0]           b_L3;
    logic                                   busy;
    logic                                   done;
    logic [N_NEURON_L3*WIDTH-1:0]           y_out;

    modport master (
        output start, a_1, a_2, w_L2, w_L3, b_L2, b_L3,
        input  busy, done, y_out
    );

    modport slave (
        input  start, a_1, a_2, w_L2, w_L3, b_L2, b_L3,
        output busy, done, y_out
    );
endinterface

// File: rtl/generator_seq_ctrl.sv
// 2-3-9 generator network evaluated on one shared signed MAC, one neuron at a time.
// Hidden activations are kept locally; outputs update per neuron and are valid from done.
module generator_seq_ctrl #(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 16,
    parameter int N_INPUT     = 2,
    parameter int N_NEURON_L2 = 3,
    parameter int N_NEURON_L3 = 9
) (
    input logic                 i_clk,
    input logic                 i_rst,
    generator_seq_ctrl_if.slave io_bus
);
    localparam int ACC_W = 2 * WIDTH + 3;
    localparam int SHR_W = ACC_W - FRAC;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] LAST_K_L2 = 2'(N_INPUT - 1);
    localparam logic [1:0] LAST_K_L3 = 2'(N_NEURON_L2 - 1);
    localparam logic [3:0] LAST_N_L2 = 4'(N_NEURON_L2 - 1);
    localparam logic [3:0] LAST_N_L3 = 4'(N_NEURON_L3 - 1);

    typedef enum logic [2:0] {StIdle, StBias, StMac, StWb, StDone} state_t;

    state_t r_state, w_state_next;

    logic signed [WIDTH-1:0] r_a1, r_a2;
    logic signed [WIDTH-1:0] r_h [N_NEURON_L2];
    logic        [WIDTH-1:0] r_y [N_NEURON_L3];
    logic signed [ACC_W-1:0] r_acc;
    logic [3:0]              r_n;
    logic [1:0]              r_k;
    logic                    r_layer;  // 0: layer 2, 1: layer 3

    logic signed [WIDTH-1:0]   w_w, w_x, w_b;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [ACC_W-1:0]          w_bias_ext, w_prod_ext;
    logic [SHR_W-1:0]          w_shr;
    logic                      w_fits;
    logic [WIDTH-1:0]          w_sat, w_relu, w_clamp;
    logic                      w_last_k, w_last_n;
    logic                      w_busy, w_done;
    logic                      w_unused_frac;
    int                        w_widx;

    // Operand select: the weight index depends on the layer's fan-in.
    always_comb begin
        w_w    = '0;
        w_b    = '0;
        w_widx = r_layer ? (N_NEURON_L2 * int'(r_n) + int'(r_k))
                         : (N_INPUT * int'(r_n) + int'(r_k));
        for (int i = 0; i < N_INPUT * N_NEURON_L2; i++) begin
            if (!r_layer && i == w_widx) w_w = io_bus.w_L2[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < N_NEURON_L2 * N_NEURON_L3; i++) begin
            if (r_layer && i == w_widx) w_w = io_bus.w_L3[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < N_NEURON_L2; i++) begin
            if (!r_layer && i == int'(r_n)) w_b = io_bus.b_L2[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < N_NEURON_L3; i++) begin
            if (r_layer && i == int'(r_n)) w_b = io_bus.b_L3[i*WIDTH +: WIDTH];
        end
        if (r_layer) w_x = r_h[r_k];
        else         w_x = (r_k == 2'd0) ? r_a1 : r_a2;
    end

    assign w_prod     = w_w * w_x;
    assign w_bias_ext = {{(ACC_W-WIDTH-FRAC){w_b[WIDTH-1]}}, w_b, {FRAC{1'b0}}};
    assign w_prod_ext = {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};

    // Fixed-point rescale, then saturate: fits when all bits above the sign agree with it.
    assign w_shr   = r_acc[ACC_W-1:FRAC];
    assign w_fits  = (w_shr[SHR_W-1:WIDTH-1] == {(SHR_W-WIDTH+1){1'b0}}) ||
                     (w_shr[SHR_W-1:WIDTH-1] == {(SHR_W-WIDTH+1){1'b1}});
    assign w_sat   = w_fits ? w_shr[WIDTH-1:0] : (w_shr[SHR_W-1] ? SAT_MIN : SAT_MAX);
    assign w_relu  = w_sat[WIDTH-1] ? '0 : w_sat;
    assign w_clamp = w_sat[WIDTH-1] ? '0 : ((w_sat > ONE) ? ONE : w_sat);
    assign w_unused_frac = ^r_acc[FRAC-1:0];

    assign w_last_k = r_layer ? (r_k == LAST_K_L3) : (r_k == LAST_K_L2);
    assign w_last_n = r_layer ? (r_n == LAST_N_L3) : (r_n == LAST_N_L2);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            StIdle: if (io_bus.start) w_state_next = StBias;
            StBias: begin
                w_busy       = 1'b1;
                w_state_next = StMac;
            end
            StMac: begin
                w_busy = 1'b1;
                if (w_last_k) w_state_next = StWb;
            end
            StWb: begin
                w_busy       = 1'b1;
                w_state_next = (r_layer && w_last_n) ? StDone : StBias;
            end
            StDone: begin
                w_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a1    <= '0;
            r_a2    <= '0;
            r_acc   <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_layer <= 1'b0;
            for (int i = 0; i < N_NEURON_L2; i++) r_h[i] <= '0;
            for (int i = 0; i < N_NEURON_L3; i++) r_y[i] <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_a1    <= io_bus.a_1;
                        r_a2    <= io_bus.a_2;
                        r_n     <= '0;
                        r_layer <= 1'b0;
                    end
                end
                StBias: begin
                    r_acc <= w_bias_ext;
                    r_k   <= '0;
                end
                StMac: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + 2'd1;
                end
                StWb: begin
                    if (r_layer) r_y[r_n]      <= w_clamp;
                    else         r_h[r_n[1:0]] <= w_relu;
                    if (!r_layer && w_last_n) begin
                        r_layer <= 1'b1;
                        r_n     <= '0;
                    end else if (!w_last_n) begin
                        r_n <= r_n + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.busy = w_busy;
    assign io_bus.done = w_done;

    for (genvar g = 0; g < N_NEURON_L3; g++) begin : g_y
        assign io_bus.y_out[g*WIDTH +: WIDTH] = r_y[g];
    end
endmodule
